// File: rtl/minitb_ahb_pkg.sv
// Shared constants for the minimal AHB slave and its bus-functional master.
//   - htrans encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - slave FSM state enum
//   - wait-state counter width and a transfer-type helper
package minitb_ahb_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned CNT_W    = 4;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    // ST_IDLE: no data phase; ST_WAIT: data phase stalled; ST_RESP: final data-phase cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // NONSEQ and SEQ start a transfer; IDLE and BUSY do not
    function automatic logic is_transfer(input logic [HTRANS_W-1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/minitb_ahb_mem.sv
// Word-addressed storage for the AHB slave.
//   clk     : clock, all writes and clears on its rising edge
//   clr     : synchronous clear of every word while high
//   we      : write enable, stores wdata at addr on the rising edge
//   addr    : word index shared by read and write
//   wdata   : write data
//   rdata_c : asynchronous read of the word at addr
module minitb_ahb_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear has priority over a write landing on the same edge
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata_c = mem_q[addr];

endmodule

// File: rtl/minitb_ahb_slave.sv
// Minimal AHB-style memory slave with a fixed number of wait states per data phase.
//   hclk    : bus clock
//   hresetn : asynchronous active-low reset
//   htrans  : transfer type (IDLE, BUSY, NONSEQ, SEQ)
//   haddr   : word address of the address phase
//   hwrite  : 1 = write, 0 = read
//   hwdata  : write data, sampled on the edge that ends the write data phase
//   hrdata  : read data in the final cycle of a read data phase, 0 otherwise
//   hready  : 1 = data phase completes this cycle / address phase can be accepted
module minitb_ahb_slave
    import minitb_ahb_pkg::*;
#(
    parameter int unsigned addrWidth  = 8,
    parameter int unsigned dataWidth  = 32,
    parameter int unsigned waitStates = 0   // 0..15
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [HTRANS_W-1:0]  htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    output logic [dataWidth-1:0] hrdata,
    output logic                 hready
);

    localparam bit               HAS_WAIT = (waitStates != 0);
    localparam logic [CNT_W-1:0] CNT_INIT = HAS_WAIT ? CNT_W'(waitStates - 1) : '0;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic                   hready_q;
    logic                   mem_clr_q;
    logic                   mem_we_c;
    logic [dataWidth-1:0]   mem_rdata_c;

    // Bus registers; hready tracks the state being entered so it is valid from the edge on
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            hready_q <= (state_d != ST_WAIT);
        end
    end

    // Memory clear request: held while reset is low, drops on the first edge after release.
    // Kept as its own flop so the storage sees a plain synchronous clear.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            mem_clr_q <= 1'b1;
        end else begin
            mem_clr_q <= 1'b0;
        end
    end

    // Next-state logic; address-phase inputs only matter when hready is high (IDLE/RESP)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (is_transfer(htrans)) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write lands only on the edge that closes its final data-phase cycle
    assign mem_we_c = (state_q == ST_RESP) && write_q;

    minitb_ahb_mem #(
        .ADDR_W (addrWidth),
        .DATA_W (dataWidth)
    ) u_mem (
        .clk     (hclk),
        .clr     (mem_clr_q),
        .we      (mem_we_c),
        .addr    (addr_q),
        .wdata   (hwdata),
        .rdata_c (mem_rdata_c)
    );

    // Read data is driven only in the final cycle of a read; zero elsewhere
    assign hrdata = ((state_q == ST_RESP) && !write_q) ? mem_rdata_c : '0;
    assign hready = hready_q;

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Self-checking bench: three slaves (waitStates 0, 2, 3) driven by independent
// pipelined masters; a transfer-level model predicts hready/hrdata every cycle.
module tb_minitb_ahb_slave;
    import minitb_ahb_pkg::*;

    localparam int NDUT = 3;
    localparam int NITEM = 128;

    typedef struct packed {
        logic [1:0]  trans;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        ck;     // check read data against ex
        logic [31:0] ex;
        logic        cs;     // check observed stall count against est
        logic [3:0]  est;
    } item_t;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  htrans_s [NDUT];
    logic [7:0]  haddr_s  [NDUT];
    logic        hwrite_s [NDUT];
    logic [31:0] hwdata_s [NDUT];
    logic [31:0] hrdata_s [NDUT];
    logic        hready_s [NDUT];

    item_t items [NDUT][NITEM];
    int    n_items [NDUT];
    int    ptr [NDUT];
    bit    slot_v [NDUT];
    bit    rdy_smp [NDUT];

    int n_tests;
    int n_fail;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        minitb_ahb_slave #(
            .addrWidth  (8),
            .dataWidth  (32),
            .waitStates ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .hclk    (hclk),
            .hresetn (hresetn),
            .htrans  (htrans_s[g]),
            .haddr   (haddr_s[g]),
            .hwrite  (hwrite_s[g]),
            .hwdata  (hwdata_s[g]),
            .hrdata  (hrdata_s[g]),
            .hready  (hready_s[g])
        );
    end

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %h, required %h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [1:0] tr, input logic [7:0] a, input logic w,
                        input logic [31:0] d, input logic ck, input logic [31:0] ex,
                        input logic cs, input logic [3:0] est);
        items[k][n_items[k]] = '{trans: tr, addr: a, wr: w, wdata: d, ck: ck, ex: ex, cs: cs, est: est};
        n_items[k]++;
    endtask

    // Put the next table item on the address bus, or an IDLE filler
    task automatic load(input int k);
        if (ptr[k] < n_items[k]) begin
            htrans_s[k] = items[k][ptr[k]].trans;
            haddr_s[k]  = items[k][ptr[k]].addr;
            hwrite_s[k] = items[k][ptr[k]].wr;
            slot_v[k]   = 1'b1;
        end else begin
            htrans_s[k] = HTRANS_IDLE;
            haddr_s[k]  = 8'($urandom);
            hwrite_s[k] = 1'($urandom);
            slot_v[k]   = 1'b0;
        end
    endtask

    // Pipelined master: address moves on when the previous cycle completed (hready=1)
    initial begin : driver
        for (int k = 0; k < NDUT; k++) begin
            htrans_s[k] = HTRANS_IDLE;
            haddr_s[k]  = 8'h00;
            hwrite_s[k] = 1'b0;
            hwdata_s[k] = $urandom;
            ptr[k]      = 0;
            slot_v[k]   = 1'b0;
        end
        forever begin
            @(posedge hclk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                if (!hresetn) begin
                    if (!slot_v[k]) load(k);
                end else if (rdy_smp[k]) begin
                    if (slot_v[k] && items[k][ptr[k]].trans[1] && items[k][ptr[k]].wr)
                        hwdata_s[k] = items[k][ptr[k]].wdata;
                    else
                        hwdata_s[k] = $urandom;
                    if (slot_v[k]) ptr[k]++;
                    slot_v[k] = 1'b0;
                    load(k);
                end
            end
        end
    end

    // Transfer-level model and per-cycle compare
    logic [31:0] mem_m [NDUT][256];
    bit          dp_v [NDUT];
    logic [7:0]  dp_addr [NDUT];
    bit          dp_wr [NDUT];
    int          wait_left [NDUT];
    int          obs_st [NDUT];
    item_t       dp_item [NDUT];

    initial begin : compare
        logic        e_rdy;
        logic [31:0] e_rd;
        bit          stalling;
        for (int k = 0; k < NDUT; k++) begin
            dp_v[k] = 1'b0;
            rdy_smp[k] = 1'b0;
            for (int i = 0; i < 256; i++) mem_m[k][i] = 32'h0;
        end
        forever begin
            @(negedge hclk);
            for (int k = 0; k < NDUT; k++) begin
                if (!hresetn) begin
                    dp_v[k] = 1'b0;
                    for (int i = 0; i < 256; i++) mem_m[k][i] = 32'h0;
                    check("hready_in_reset", k, 32'(hready_s[k]), 32'd1);
                    check("hrdata_in_reset", k, hrdata_s[k], 32'h0);
                    rdy_smp[k] = 1'b0;
                end else begin
                    stalling = dp_v[k] && (wait_left[k] > 0);
                    e_rdy = !stalling;
                    e_rd  = (dp_v[k] && !dp_wr[k] && !stalling) ? mem_m[k][dp_addr[k]] : 32'h0;
                    check("hready", k, 32'(hready_s[k]), 32'(e_rdy));
                    check("hrdata", k, hrdata_s[k], e_rd);
                    rdy_smp[k] = hready_s[k];
                    if (dp_v[k] && !hready_s[k]) obs_st[k]++;
                    if (stalling) begin
                        wait_left[k]--;
                    end else begin
                        if (dp_v[k]) begin
                            if (dp_item[k].ck && !dp_wr[k])
                                check("read_value", k, hrdata_s[k], dp_item[k].ex);
                            if (dp_item[k].cs)
                                check("stall_cycles", k, 32'(obs_st[k]), 32'(dp_item[k].est));
                            if (dp_wr[k]) mem_m[k][dp_addr[k]] = hwdata_s[k];
                        end
                        dp_v[k] = 1'b0;
                        if (htrans_s[k][1]) begin
                            dp_v[k]      = 1'b1;
                            dp_addr[k]   = haddr_s[k];
                            dp_wr[k]     = hwrite_s[k];
                            wait_left[k] = ws_of(k);
                            obs_st[k]    = 0;
                            dp_item[k]   = slot_v[k] ? items[k][ptr[k]] : '0;
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(negedge hclk);
            ok = 1'b1;
            for (int k = 0; k < NDUT; k++)
                if (ptr[k] != n_items[k] || slot_v[k]) ok = 1'b0;
        end
        repeat (6) @(negedge hclk);
        check(nm, 0, 32'(ok), 32'd1);
    endtask

    initial begin : main
        bit          found;
        logic [3:0]  ws;
        int          r;
        n_tests = 0;
        n_fail  = 0;
        hresetn = 1'b1;
        for (int k = 0; k < NDUT; k++) n_items[k] = 0;

        for (int k = 0; k < NDUT; k++) begin
            ws = (k == 0) ? 4'd0 : ((k == 1) ? 4'd2 : 4'd3);
            push(k, HTRANS_NONSEQ, 8'h55, 1'b0, $urandom, 1'b1, 32'h0, 1'b1, ws);
            push(k, HTRANS_NONSEQ, 8'h10, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, ws);
            push(k, HTRANS_NONSEQ, 8'h10, 1'b0, $urandom, 1'b1, 32'hDEADBEEF, 1'b1, ws);
            push(k, HTRANS_IDLE,   8'h00, 1'b0, $urandom, 1'b0, 32'h0, 1'b0, 4'd0);
            push(k, HTRANS_NONSEQ, 8'h04, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b1, ws);
            push(k, HTRANS_SEQ,    8'h04, 1'b0, $urandom, 1'b1, 32'h12345678, 1'b1, ws);
            push(k, HTRANS_NONSEQ, 8'h20, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, ws);
            push(k, HTRANS_NONSEQ, 8'h20, 1'b0, $urandom, 1'b1, 32'hA5A5A5A5, 1'b1, ws);
            push(k, HTRANS_BUSY,   8'h30, 1'b0, $urandom, 1'b0, 32'h0, 1'b0, 4'd0);
            push(k, HTRANS_SEQ,    8'h30, 1'b0, $urandom, 1'b1, 32'h0, 1'b1, ws);
            push(k, HTRANS_IDLE,   8'h00, 1'b0, $urandom, 1'b0, 32'h0, 1'b0, 4'd0);
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 7);
                push(k, (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 5) ? HTRANS_NONSEQ : HTRANS_SEQ,
                     ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                     1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 4'd0);
            end
        end

        #1 hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #2 hresetn = 1'b1;
        drain("drain_directed_random");

        // Reset in the middle of a stalled write on the two-wait-state slave
        push(1, HTRANS_NONSEQ, 8'h08, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 4'd0);
        push(1, HTRANS_NONSEQ, 8'h08, 1'b0, $urandom, 1'b1, 32'h0, 1'b1, 4'd2);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge hclk);
            if (!hready_s[1]) found = 1'b1;
        end
        check("stall_reached", 1, 32'(found), 32'd1);
        #1 hresetn = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("hready_at_reset", k, 32'(hready_s[k]), 32'd1);
            check("hrdata_at_reset", k, hrdata_s[k], 32'h0);
        end
        push(0, HTRANS_NONSEQ, 8'h10, 1'b0, $urandom, 1'b1, 32'h0, 1'b1, 4'd0);
        push(2, HTRANS_NONSEQ, 8'h04, 1'b0, $urandom, 1'b1, 32'h0, 1'b1, 4'd3);
        repeat (2) @(posedge hclk);
        #2 hresetn = 1'b1;
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
